// File: rtl/display_share_arbiter_pkg.sv
// Shared constants and types for the display share arbiter.
// Display word width, default dwell and the two-state arbiter encoding.
package display_pkg;

  localparam int DISP_W          = 32;
  localparam int HOLD_CYCLES_DEF = 50_000_000;

  typedef enum logic {
    IDLE,
    SHOW
  } disp_arb_state_t;

endpackage

// File: rtl/display_share_arbiter_if.sv
// Requester-side bus of the display share arbiter: requests, values, freeze and grant outputs.
// The slave modport is the arbiter's view; master is the application/top-level side.
interface display_share_arbiter_if #(
  parameter int N_REQ = 4
);
  import display_pkg::*;

  logic [N_REQ-1:0]        req_in;
  logic [DISP_W*N_REQ-1:0] val_in;
  logic                    freeze_in;
  logic [N_REQ-1:0]        grant_out;
  logic [N_REQ-1:0]        ack_out;
  logic [DISP_W-1:0]       val_out;
  logic                    active_out;

  modport master (
    output req_in, val_in, freeze_in,
    input  grant_out, ack_out, val_out, active_out
  );

  modport slave (
    input  req_in, val_in, freeze_in,
    output grant_out, ack_out, val_out, active_out
  );

endinterface

// File: rtl/display_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first active request strictly after i_last, wrapping.
// The search covers all N_REQ slots, so i_last itself is chosen only when it is the sole request.
module rr_pick
  import display_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_pick,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j      = 0;
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(i_last) + k) % N_REQ;
      if (!o_any && i_req[j]) begin
        o_any     = 1'b1;
        o_pick[j] = 1'b1;
        o_idx     = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin time-share of the 7-segment display value among N_REQ requesters.
// Grant, ack and value are registered: one cycle from request/drop to new owner.
module display_share_arbiter
  import display_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int HOLD_CYCLES = HOLD_CYCLES_DEF,
  localparam int CNT_W       = $clog2(HOLD_CYCLES),
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  display_share_arbiter_if.slave bus
);

  disp_arb_state_t   r_state, w_nxt_state;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic [IDX_W-1:0]  r_last, w_nxt_last;
  logic [N_REQ-1:0]  r_grant, w_nxt_grant;
  logic [N_REQ-1:0]  r_ack, w_nxt_ack;
  logic [DISP_W-1:0] r_val, w_nxt_val;

  logic [N_REQ-1:0]  w_pick;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_any;
  logic              w_expire;
  logic              w_drop;

  // One picker serves start, rotation and release: all search from last_owner+1.
  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_req  (bus.req_in),
    .i_last (r_last),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_any)
  );

  assign w_expire = (r_cnt == CNT_W'(HOLD_CYCLES - 1)) && !bus.freeze_in;
  assign w_drop   = !bus.req_in[r_last];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_last  = r_last;
    w_nxt_grant = r_grant;
    w_nxt_ack   = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_nxt_state = SHOW;
          w_nxt_cnt   = '0;
          w_nxt_last  = w_pick_idx;
          w_nxt_grant = w_pick;
          w_nxt_ack   = w_pick;
        end
      end
      SHOW: begin
        // A drop wins over freeze; expiry coinciding with a drop resolves identically.
        if (w_drop || w_expire) begin
          w_nxt_cnt = '0;
          if (w_any) begin
            w_nxt_last  = w_pick_idx;
            w_nxt_grant = w_pick;
            if (w_pick_idx != r_last) begin
              w_nxt_ack = w_pick;
            end
          end else begin
            w_nxt_state = IDLE;
            w_nxt_grant = '0;
          end
        end else if (!bus.freeze_in) begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  // Value follows the next owner so it changes together with grant_out.
  always_comb begin
    w_nxt_val = '0;
    if (w_nxt_state == SHOW) begin
      w_nxt_val = bus.val_in[int'(w_nxt_last)*DISP_W +: DISP_W];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt   <= '0;
      r_last  <= IDX_W'(N_REQ - 1);
      r_grant <= '0;
      r_ack   <= '0;
      r_val   <= '0;
    end else begin
      r_cnt   <= w_nxt_cnt;
      r_last  <= w_nxt_last;
      r_grant <= w_nxt_grant;
      r_ack   <= w_nxt_ack;
      r_val   <= w_nxt_val;
    end
  end

  assign bus.grant_out  = r_grant;
  assign bus.ack_out    = r_ack;
  assign bus.val_out    = r_val;
  assign bus.active_out = (r_state == SHOW);

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter (N_REQ=4, HOLD_CYCLES=4) with a queued scoreboard.
module tb_display_share_arbiter;

  localparam logic [31:0] V0 = 32'h1234_5678;
  localparam logic [31:0] V1 = 32'hAAAA_0001;
  localparam logic [31:0] V2 = 32'hBBBB_0002;
  localparam logic [31:0] V3 = 32'hCCCC_0003;
  localparam logic [31:0] VL = 32'hDEAD_BEEF;

  typedef struct {
    logic [3:0]  g;
    logic [3:0]  a;
    logic [31:0] v;
    logic        act;
    int          id;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;
  int   step_id;

  display_share_arbiter_if #(.N_REQ(4)) bus ();

  display_share_arbiter #(
    .N_REQ       (4),
    .HOLD_CYCLES (4)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input exp_t e);
    n_vec++;
    if (bus.grant_out !== e.g || bus.ack_out !== e.a ||
        bus.val_out !== e.v || bus.active_out !== e.act) begin
      n_bad++;
      $display("FAIL vec%0d: got grant=%b ack=%b val=%h active=%b, want grant=%b ack=%b val=%h active=%b",
               e.id, bus.grant_out, bus.ack_out, bus.val_out, bus.active_out,
               e.g, e.a, e.v, e.act);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what must appear after the next rise.
  task automatic step(input logic [3:0] req, input logic frz,
                      input logic [3:0] g, input logic [3:0] a,
                      input logic [31:0] v, input logic act);
    exp_t e;
    @(negedge clk);
    bus.req_in    = req;
    bus.freeze_in = frz;
    e.g   = g;
    e.a   = a;
    e.v   = v;
    e.act = act;
    e.id  = step_id;
    step_id++;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e);
      end
    end
  end

  initial begin : driver
    exp_t z;
    n_vec   = 0;
    n_bad   = 0;
    step_id = 0;
    rst_n   = 1'b0;
    bus.req_in    = '0;
    bus.freeze_in = 1'b0;
    bus.val_in    = {V3, V2, V1, V0};

    // Reset state
    step(4'b0000, 0, 4'b0000, 4'b0000, 32'h0, 0);
    step(4'b0000, 0, 4'b0000, 4'b0000, 32'h0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single requester: grant, then dwell restart with no ack
    step(4'b0001, 0, 4'b0001, 4'b0001, V0, 1);
    for (int i = 0; i < 5; i++) step(4'b0001, 0, 4'b0001, 4'b0000, V0, 1);

    // Round-robin over requesters 0,1,3
    for (int i = 0; i < 2; i++) step(4'b1011, 0, 4'b0001, 4'b0000, V0, 1);
    step(4'b1011, 0, 4'b0010, 4'b0010, V1, 1);
    for (int i = 0; i < 3; i++) step(4'b1011, 0, 4'b0010, 4'b0000, V1, 1);
    step(4'b1011, 0, 4'b1000, 4'b1000, V3, 1);
    for (int i = 0; i < 3; i++) step(4'b1011, 0, 4'b1000, 4'b0000, V3, 1);
    step(4'b1011, 0, 4'b0001, 4'b0001, V0, 1);
    for (int i = 0; i < 3; i++) step(4'b1011, 0, 4'b0001, 4'b0000, V0, 1);
    step(4'b1011, 0, 4'b0010, 4'b0010, V1, 1);

    // Early release: owner 1 drops in dwell cycle 2 with 3 pending, then release to idle
    step(4'b1011, 0, 4'b0010, 4'b0000, V1, 1);
    step(4'b1001, 0, 4'b1000, 4'b1000, V3, 1);
    step(4'b0010, 0, 4'b0010, 4'b0010, V1, 1);
    step(4'b0010, 0, 4'b0010, 4'b0000, V1, 1);
    step(4'b0000, 0, 4'b0000, 4'b0000, 32'h0, 0);

    // Freeze after two dwell cycles; two more cycles after unfreeze then rotate
    step(4'b0011, 0, 4'b0001, 4'b0001, V0, 1);
    step(4'b0011, 0, 4'b0001, 4'b0000, V0, 1);
    for (int i = 0; i < 10; i++) step(4'b0011, 1, 4'b0001, 4'b0000, V0, 1);
    step(4'b0011, 0, 4'b0001, 4'b0000, V0, 1);
    step(4'b0011, 0, 4'b0001, 4'b0000, V0, 1);
    step(4'b0011, 0, 4'b0010, 4'b0010, V1, 1);

    // Drop honoured while frozen
    step(4'b0001, 1, 4'b0001, 4'b0001, V0, 1);
    step(4'b0001, 0, 4'b0001, 4'b0000, V0, 1);

    // Live value update of the owner
    @(posedge clk);
    #2 bus.val_in[31:0] = VL;
    step(4'b0001, 0, 4'b0001, 4'b0000, VL, 1);

    // Asynchronous reset between edges, mid-dwell
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    z.g = 4'b0000; z.a = 4'b0000; z.v = 32'h0; z.act = 1'b0; z.id = -1;
    compare(z);
    step(4'b1111, 0, 4'b0000, 4'b0000, 32'h0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First grant after reset goes to requester 0
    step(4'b1111, 0, 4'b0001, 4'b0001, VL, 1);
    for (int i = 0; i < 3; i++) step(4'b1111, 0, 4'b0001, 4'b0000, VL, 1);
    step(4'b1111, 0, 4'b0010, 4'b0010, V1, 1);

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/display_share_arbiter.md
# display_share_arbiter

Time-shares the 32-bit value input of the board's 8-digit seven-segment display controller between up to `N_REQ` requester blocks. Each requester raises a request and presents the value it wants shown. The arbiter grants ownership round-robin, holds each owner on the display for a fixed dwell time, and drives the selected value to the display controller's `val_in`. It sits between the application blocks and the seven-segment display controller in the top level.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `HOLD_CYCLES`, default 50_000_000: dwell per grant, in clock cycles (0.5 s at 100 MHz); must be ≥ 2.
- `clk_in` input, 1 bit: system clock. Single clock domain.
- `rst_n_in` input, 1 bit: reset, asynchronous, active-low.
- `req_in` input, `N_REQ` bits: level request, one bit per requester.
- `val_in` input, `32*N_REQ` bits: flattened display values; requester i occupies `[32*i+31:32*i]`.
- `freeze_in` input, 1 bit: while high, the dwell counter is held and no timed rotation occurs.
- `grant_out` output, `N_REQ` bits: one-hot current owner; all zero when idle.
- `ack_out` output, `N_REQ` bits: one-cycle pulse on the bit of a newly granted owner.
- `val_out` output, 32 bits: value to drive the display controller's `val_in`.
- `active_out` output, 1 bit: high while any owner is granted.

## Operation
- **States**:
  - IDLE: no owner; `val_out` = 0.
  - SHOW: an owner is granted and the dwell counter runs.
- **Round-robin pick**: search starts at `last_owner+1` and wraps modulo `N_REQ`. On reset, `last_owner` = `N_REQ-1`, so requester 0 has first priority.
- **IDLE → SHOW**: when `req_in` ≠ 0.
  - Pick the owner.
  - Counter ← 0.
  - Pulse `ack_out[owner]`.
  - Record `last_owner`.
- **SHOW, counter reaches `HOLD_CYCLES-1` with `freeze_in` low**:
  - Another requester is active: rotate to the next round-robin pick, pulse its ack, counter ← 0.
  - Only the current owner is requesting: keep the owner, counter ← 0, no ack pulse.
  - No requester is active: go to IDLE.
- **Owner drops `req_in` mid-dwell**: release immediately, regardless of `freeze_in`.
  - Rearbitrate among the remaining requests (search starts after the dropped owner).
  - If none remain, go to IDLE.
- **freeze_in high**: owner and counter hold their values. Request drops are still honoured.
- **val_out**:
  - Registered copy of `val_in` slice[owner], updated every cycle while in SHOW, so live owner updates pass through.
  - Forced to 0 in IDLE.
- **Simultaneous events**: dwell expiry and an owner drop in the same cycle are handled as a drop. Both give the same round-robin result.
- **Reset values** (asserted at any time, including mid-dwell): state IDLE, `grant_out` = 0, `ack_out` = 0, `val_out` = 0, `active_out` = 0, counter = 0.

## Timing
- **Grant latency**: one cycle. A request sampled high at edge k gives `grant_out`, `ack_out` and `active_out` valid after edge k.
- **Value timing**: `val_out` reflects the new owner's value in the same cycle that `grant_out` changes. It then tracks `val_in[owner]` with one cycle of latency.
- **Dwell length**: exactly `HOLD_CYCLES` cycles from grant to rotation, with `freeze_in` low and requests steady.
- **Release latency**: an owner drop sampled at edge k removes its grant after edge k. The next owner, or IDLE, is visible in that same cycle.
- **Counter width**: `$clog2(HOLD_CYCLES)`. The counter never exceeds `HOLD_CYCLES-1`.
- **Outputs**: all outputs are registered, with no combinational path from input to output.

## Structure
- **Package `display_pkg`**:
  - `DISP_W` = 32.
  - `typedef enum logic {IDLE, SHOW} disp_arb_state_t`.
  - Default `HOLD_CYCLES` constant.
- **Sub-module `rr_pick`**: combinational.
  - Inputs: request vector and last-owner index.
  - Outputs: one-hot pick, encoded index and `any`.
  - Reused for both the initial grant and rotation.
- **Top module**: state register, dwell counter, `last_owner` register and `val_out` mux register.

## Test plan
Use `HOLD_CYCLES` = 4 and `N_REQ` = 4 in simulation.
- **Single requester, start and dwell restart**: reset, then `req_in` = 0001 and `val_in[0]` = 32'h1234_5678.
  - Next cycle: `grant_out` = 0001, `ack_out` = 0001 for one cycle, `val_out` = 32'h1234_5678.
  - After 4 cycles, grant is kept and no new ack occurs.
- **Round-robin rotation**: `req_in` = 1011 held.
  - Grant order is 0001 → 0010 → 1000 → 0001, each owner held exactly 4 cycles, with one ack per change.
- **Early release**: owner 1 drops `req_in` in dwell cycle 2 while request 3 is pending.
  - Next cycle: `grant_out` = 1000, `ack_out[3]` pulses.
  - If instead no other requester is active: IDLE, `val_out` = 0, `active_out` = 0.
- **Freeze**: with `freeze_in` high for 10 cycles and `req_in` = 0011, the owner stays 0001 the whole time.
  - Rotation occurs exactly 4 − elapsed cycles after `freeze_in` falls.
- **Live value and async reset**: change `val_in[owner]` → `val_out` follows one cycle later.
  - Pulse `rst_n_in` low between clock edges mid-dwell → all outputs are 0 immediately.
  - After release with `req_in` = 1111, the first grant goes to requester 0.
